argmax_out: RTL

Classifier output stage placed directly downstream of the final time-multiplexed dense layer. On a `start` pulse it snapshots all N_IN signed activations, scans them sequentially one per clock, and reports the index and value of the largest activation with a one-cycle valid strobe. The snapshot decouples the scan from the upstream layer, which keeps rotating its neuron outputs freely.

---
 rtl/argmax_pkg.sv | 14 +
 rtl/argmax_cmp.sv | 42 ++++
 rtl/argmax_out.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/argmax_pkg.sv
// Shared types and default sizing for the argmax classifier output stage.
// These defaults are also used by the final-layer wrapper.
package argmax_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam int N_IN_DEF   = 30;
    localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/argmax_cmp.sv
// Combinational signed compare-and-select for one scan step.
// Tracks the runner-up as well when ARGMAX_MARGIN_EN is defined.
module argmax_cmp #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 5
) (
    input  logic signed [DATA_W-1:0] cand_val_i,
    input  logic        [IDX_W-1:0]  cand_idx_i,
    input  logic signed [DATA_W-1:0] best_val_i,
    input  logic        [IDX_W-1:0]  best_idx_i,
    output logic signed [DATA_W-1:0] best_val_o,
    output logic        [IDX_W-1:0]  best_idx_o
`ifdef ARGMAX_MARGIN_EN
    ,
    input  logic signed [DATA_W-1:0] run_val_i,
    output logic signed [DATA_W-1:0] run_val_o
`endif
);

    logic take;

    // Strict greater-than: on ties the earlier (lower) index is kept.
    assign take = (cand_val_i > best_val_i);

    always_comb begin
        best_val_o = take ? cand_val_i : best_val_i;
        best_idx_o = take ? cand_idx_i : best_idx_i;
    end

`ifdef ARGMAX_MARGIN_EN
    always_comb begin
        if (take) begin
            run_val_o = best_val_i;
        end else if (cand_val_i > run_val_i) begin
            run_val_o = cand_val_i;
        end else begin
            run_val_o = run_val_i;
        end
    end
`endif

endmodule

// File: rtl/argmax_out.sv
// Snapshots N_IN signed activations on start, scans them one per clock and
// reports the argmax with a one-cycle valid strobe. Optional ARGMAX_MARGIN_EN adds max minus runner-up.
module argmax_out
    import argmax_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = $clog2(N_IN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [N_IN*DATA_W-1:0]   in_flat,
    output logic                     busy,
    output logic                     class_valid,
    output logic [IDX_W-1:0]         class_idx,
    output logic [DATA_W-1:0]        max_val
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [DATA_W:0]          margin
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

    state_t state_q, state_d;

    logic signed [DATA_W-1:0] snap_q [N_IN];
    logic signed [DATA_W-1:0] snap_d [N_IN];
    logic signed [DATA_W-1:0] best_val_q, best_val_d;
    logic [IDX_W-1:0]         best_idx_q, best_idx_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     valid_q, valid_d;
    logic [IDX_W-1:0]         class_idx_q, class_idx_d;
    logic [DATA_W-1:0]        max_val_q, max_val_d;

    logic signed [DATA_W-1:0] cmp_val;
    logic [IDX_W-1:0]         cmp_idx;

`ifdef ARGMAX_MARGIN_EN
    logic signed [DATA_W-1:0] run_q, run_d, cmp_run;
    logic [DATA_W:0]          margin_q, margin_d;
`endif

    argmax_cmp #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_cmp (
        .cand_val_i (snap_q[idx_q]),
        .cand_idx_i (idx_q),
        .best_val_i (best_val_q),
        .best_idx_i (best_idx_q),
        .best_val_o (cmp_val),
        .best_idx_o (cmp_idx)
`ifdef ARGMAX_MARGIN_EN
        ,
        .run_val_i  (run_q),
        .run_val_o  (cmp_run)
`endif
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        class_valid = valid_q;
        class_idx   = class_idx_q;
        max_val     = max_val_q;
`ifdef ARGMAX_MARGIN_EN
        margin      = margin_q;
`endif
    end

    always_comb begin
        snap_d      = snap_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        idx_d       = idx_q;
        valid_d     = 1'b0;
        class_idx_d = class_idx_q;
        max_val_d   = max_val_q;
`ifdef ARGMAX_MARGIN_EN
        run_d       = run_q;
        margin_d    = margin_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int unsigned i = 0; i < N_IN; i++) begin
                        snap_d[i] = in_flat[i*DATA_W +: DATA_W];
                    end
                    best_val_d = in_flat[DATA_W-1:0];
                    best_idx_d = '0;
                    idx_d      = IDX_W'(1);
`ifdef ARGMAX_MARGIN_EN
                    // Runner-up starts at the most negative value so any element displaces it.
                    run_d      = {1'b1, {(DATA_W-1){1'b0}}};
`endif
                end
            end
            SCAN: begin
                best_val_d = cmp_val;
                best_idx_d = cmp_idx;
                idx_d      = idx_q + IDX_W'(1);
`ifdef ARGMAX_MARGIN_EN
                run_d      = cmp_run;
`endif
            end
            DONE: begin
                valid_d     = 1'b1;
                class_idx_d = best_idx_q;
                max_val_d   = best_val_q;
`ifdef ARGMAX_MARGIN_EN
                margin_d    = {best_val_q[DATA_W-1], best_val_q} - {run_q[DATA_W-1], run_q};
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                snap_q[i] <= '0;
            end
            best_val_q  <= '0;
            best_idx_q  <= '0;
            idx_q       <= '0;
            valid_q     <= 1'b0;
            class_idx_q <= '0;
            max_val_q   <= '0;
`ifdef ARGMAX_MARGIN_EN
            run_q       <= '0;
            margin_q    <= '0;
`endif
        end else begin
            snap_q      <= snap_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            idx_q       <= idx_d;
            valid_q     <= valid_d;
            class_idx_q <= class_idx_d;
            max_val_q   <= max_val_d;
`ifdef ARGMAX_MARGIN_EN
            run_q       <= run_d;
            margin_q    <= margin_d;
`endif
        end
    end

endmodule
